// File: rtl/async_com_pkg.sv
// Shared types and sizing helpers for the async_com_serial link.
// ASYNC_COM_PARITY_EN adds a trailing even-parity beat to every frame.
package async_com_pkg;

`ifdef ASYNC_COM_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        SEND_WAIT,
        READ,
        ACK
    } state_t;

    function automatic int beats(input int data_w, input int bus_w, input bit parity);
        return data_w / bus_w + (parity ? 1 : 0);
    endfunction

    function automatic int cnt_width(input int nbeats, input int timeout);
        return $clog2(((nbeats > timeout) ? nbeats : timeout) + 1);
    endfunction

    // Width for the default configuration; instances recompute with cnt_width().
    localparam int CNT_W = cnt_width(beats(8, 1, PARITY_EN), 16);

endpackage

// File: rtl/async_com_timer.sv
// Acknowledge-timeout counter: cleared outside SEND_WAIT, counts while enabled,
// flags expiry once it has sat ACK_TIMEOUT-1 cycles.
module async_com_timer
    import async_com_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CW          = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    if (ACK_TIMEOUT < 2) begin : g_bad_timeout
        $error("async_com_timer: ACK_TIMEOUT must be >= 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/async_com_serial.sv
// Word transfer over a shared BUS_W tri-state bus with req/ack handshake and
// ack timeout. ASYNC_COM_PARITY_EN appends and checks an even-parity beat.
module async_com_serial
    import async_com_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BUS_W       = 1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              tx_err,
    input  logic              peer_req,
    input  logic              peer_ack,
    output logic              own_req,
    output logic              own_ack,
    inout  wire  [BUS_W-1:0]  data_bus,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err
);

    localparam int BEATS = beats(DATA_W, BUS_W, PARITY_EN);
    localparam int SH_W  = BEATS * BUS_W;
    localparam int CW    = cnt_width(BEATS, ACK_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if (DATA_W % BUS_W != 0) begin : g_bad_width
        $error("async_com_serial: DATA_W must be a multiple of BUS_W");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SH_W-1:0]   tx_sh_q, tx_sh_d;
    logic [SH_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_err_q, tx_err_d;
    logic              rx_err_q, rx_err_d;
    logic [SH_W-1:0]   tx_load;
    logic [SH_W-1:0]   rx_shift;
    logic              rx_bad;
    logic              tmr_expired;

    // Beats arrive LSB first, so shift right and insert at the top.
    assign rx_shift = (rx_sh_q >> BUS_W) | (SH_W'(data_bus) << (SH_W - BUS_W));

`ifdef ASYNC_COM_PARITY_EN
    assign tx_load = {BUS_W'(^tx_data), tx_data};
    assign rx_bad  = (rx_shift[SH_W-1:DATA_W] != BUS_W'(^rx_shift[DATA_W-1:0]));
`else
    assign tx_load = tx_data;
    assign rx_bad  = 1'b0;
`endif

    async_com_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .CW         (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != SEND_WAIT),
        .en_i     (state_q == SEND_WAIT),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        tx_done_d = 1'b0;
        tx_err_d  = 1'b0;
        rx_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (peer_req) begin
                    rx_sh_d = rx_shift;
                    cnt_d   = CW'(1);
                    if (BEATS == 1) begin
                        state_d   = ACK;
                        rx_data_d = rx_shift[DATA_W-1:0];
                    end else begin
                        state_d = READ;
                    end
                end else if (start) begin
                    tx_sh_d = tx_load;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_sh_d = tx_sh_q >> BUS_W;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                if (peer_ack) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end else if (tmr_expired) begin
                    state_d  = IDLE;
                    tx_err_d = 1'b1;
                end
            end
            READ: begin
                if (!peer_req) begin
                    // Peer dropped out mid-frame: discard, keep the old word.
                    state_d  = IDLE;
                    cnt_d    = '0;
                    rx_err_d = 1'b1;
                end else begin
                    rx_sh_d = rx_shift;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (rx_bad) begin
                            state_d  = IDLE;
                            rx_err_d = 1'b1;
                        end else begin
                            state_d   = ACK;
                            rx_data_d = rx_shift[DATA_W-1:0];
                        end
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            tx_done_q <= tx_done_d;
            tx_err_q  <= tx_err_d;
            rx_err_q  <= rx_err_d;
        end
    end

    assign own_req  = (state_q == SEND);
    assign own_ack  = (state_q == ACK);
    assign rx_valid = own_ack;
    assign tx_ready = (state_q == IDLE) && !peer_req;
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;
    assign rx_err   = rx_err_q;
    assign rx_data  = rx_data_q;
    assign data_bus = own_req ? tx_sh_q[BUS_W-1:0] : {BUS_W{1'bz}};

endmodule

// File: tb/tb_async_com_serial.sv
// Two async_com_serial instances, A -> B link with tb-controlled fault injection;
// expected pulses are queued by the stimulus and popped by a monitor.
module tb_async_com_serial;
    import async_com_pkg::*;

    localparam int DATA_W = 8;
    localparam int BUS_W  = 2;
    localparam int TO     = 16;
    localparam int BEATS  = beats(DATA_W, BUS_W, PARITY_EN);

    localparam int A_DONE = 0, A_TERR = 1, A_RXV = 2, A_RERR = 3;
    localparam int B_DONE = 4, B_TERR = 5, B_RXV = 6, B_RERR = 7;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] txd_a = '0, txd_b = '0;
    logic       a_preq = 1'b0;
    logic       ovr_b = 1'b0;
    logic [1:0] corr = 2'b00;

    logic       a_rdy, a_done, a_terr, a_req, a_ack, a_rxv, a_rerr;
    logic       b_rdy, b_done, b_terr, b_req, b_ack, b_rxv, b_rerr;
    logic [7:0] a_rxd, b_rxd;
    logic       b_preq;
    wire  [1:0] bus_a, bus_b;

    pullup (bus_a);
    pullup (bus_b);
    assign bus_b  = a_req ? (bus_a ^ corr) : 2'bzz;
    assign b_preq = ovr_b ? 1'b0 : a_req;

    async_com_serial #(.DATA_W(DATA_W), .BUS_W(BUS_W), .ACK_TIMEOUT(TO)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .tx_data(txd_a), .tx_ready(a_rdy),
        .tx_done(a_done), .tx_err(a_terr), .peer_req(a_preq), .peer_ack(b_ack),
        .own_req(a_req), .own_ack(a_ack), .data_bus(bus_a), .rx_data(a_rxd),
        .rx_valid(a_rxv), .rx_err(a_rerr)
    );

    async_com_serial #(.DATA_W(DATA_W), .BUS_W(BUS_W), .ACK_TIMEOUT(TO)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .tx_data(txd_b), .tx_ready(b_rdy),
        .tx_done(b_done), .tx_err(b_terr), .peer_req(b_preq), .peer_ack(a_ack),
        .own_req(b_req), .own_ack(b_ack), .data_bus(bus_b), .rx_data(b_rxd),
        .rx_valid(b_rxv), .rx_err(b_rerr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        sb.push_back(e);
    endtask

    // Leaves the caller at the negedge inside cycle 0 of the frame.
    task automatic kick_a(input logic [7:0] w, output int t0);
        @(negedge clk);
        start_a = 1'b1;
        txd_a   = w;
        t0      = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    logic [7:0] pul;
    assign pul = {b_rerr, b_rxv, b_terr, b_done, a_rerr, a_rxv, a_terr, a_done};

    always @(posedge clk) begin
        ev_t e;
        #2;
        for (int i = 0; i < 8; i++) begin
            if (pul[i]) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: pulse kind %0d at cycle %0d, none expected", i, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_kind", i, e.kind);
                    chk("sb_cycle", cyc, e.cyc);
                    if (i == A_RXV) chk("sb_rx_data_a", a_rxd, e.data);
                    if (i == B_RXV) chk("sb_rx_data_b", b_rxd, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d expected events left", sb.size());
        $fatal(1, "watchdog");
    end

    // 0xB4 in 2-bit beats, LSB first, then the parity beat (four ones -> 0).
    logic [1:0] beat_b4 [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0};

    initial begin
        int t0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_own_req", a_req, 1'b0);
        chk("rst_bus_z", bus_a, 2'b11);
        chk("rst_rx_data", b_rxd, 8'h00);
        chk("rst_pulses", {a_done, a_terr, b_rxv, b_rerr, b_ack}, 5'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("idle_tx_ready", a_rdy, 1'b1);

        // Loopback transfer of 0xB4
        kick_a(8'hB4, t0);
        push(B_RXV, t0 + BEATS, 8'hB4);
        push(A_DONE, t0 + BEATS + 1, 8'h00);
        for (int k = 0; k < BEATS; k++) begin
            chk("t1_beat", bus_b, beat_b4[k]);
            chk("t1_own_req", a_req, 1'b1);
            @(negedge clk);
        end
        chk("t1_own_ack", b_ack, 1'b1);
        repeat (3) @(negedge clk);
        chk("t1_rx_data", b_rxd, 8'hB4);
        chk("t1_bus_released", bus_a, 2'b11);
        chk("t1_ready_again", a_rdy, 1'b1);

        // No peer: ack timeout
        rst_b = 1'b1;
        kick_a(8'h3C, t0);
        push(A_TERR, t0 + BEATS + TO, 8'h00);
        repeat (BEATS + TO) @(negedge clk);
        chk("t2_tx_err", a_terr, 1'b1);
        chk("t2_bus_z", bus_a, 2'b11);
        chk("t2_own_req", a_req, 1'b0);
        @(negedge clk);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // Receive has priority over a pending start
        kick_a(8'h96, t0);
        chk("t3_tx_ready_busy", b_rdy, 1'b0);
        start_b = 1'b1;
        txd_b   = 8'h5A;
        push(B_RXV, t0 + BEATS, 8'h96);
        push(A_DONE, t0 + BEATS + 1, 8'h00);
        push(B_TERR, t0 + 2 * BEATS + 2 + TO, 8'h00);
        for (int c = 1; c <= BEATS + 2; c++) begin
            @(negedge clk);
            if (c <= BEATS) chk("t3_no_send", b_req, 1'b0);
            if (c == BEATS + 1) chk("t3_ready_after", b_rdy, 1'b1);
            if (c == BEATS + 2) begin
                chk("t3_start_taken", b_req, 1'b1);
                start_b = 1'b0;
            end
        end
        repeat (BEATS + TO + 2) @(negedge clk);

        // Truncated frame: peer_req drops after two beats
        kick_a(8'h0F, t0);
        push(B_RERR, t0 + 3, 8'h00);
        push(A_TERR, t0 + BEATS + TO, 8'h00);
        repeat (2) @(negedge clk);
        ovr_b = 1'b1;
        for (int c = 2; c <= BEATS + TO + 1; c++) begin
            chk("t4_no_ack", b_ack, 1'b0);
            @(negedge clk);
        end
        ovr_b = 1'b0;
        chk("t4_rx_data_kept", b_rxd, 8'h96);
        @(negedge clk);

        // Reset during beat 2 of a send
        kick_a(8'h00, t0);
        push(B_RERR, t0 + 3, 8'h00);
        repeat (2) @(negedge clk);
        chk("t5_beat2_driven", bus_a, 2'b00);
        rst_a = 1'b1;
        #1;
        chk("t5_own_req", a_req, 1'b0);
        chk("t5_bus_z", bus_a, 2'b11);
        chk("t5_pulses", {a_done, a_terr, a_rxv, a_rerr, a_ack}, 5'b0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_rx_data_kept", b_rxd, 8'h96);

`ifdef ASYNC_COM_PARITY_EN
        // Corrupted parity beat for 0x01 (correct beat is 2'b01)
        kick_a(8'h01, t0);
        push(B_RERR, t0 + BEATS, 8'h00);
        push(A_TERR, t0 + BEATS + TO, 8'h00);
        repeat (BEATS - 1) @(negedge clk);
        corr = 2'b01;
        @(negedge clk);
        corr = 2'b00;
        repeat (TO + 2) @(negedge clk);
        chk("t6_rx_data_kept", b_rxd, 8'h96);
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/async_com_serial.md
Name: async_com_serial

Overview:
- Parametrised successor to the single-bit shared-wire communicator.
- Moves a DATA_W-bit word between two peers over a shared BUS_W-bit tri-state bus, one beat per clock, LSB beat first.
- Request/acknowledge handshake with an acknowledge timeout, so one instance can act as sender or receiver.
- Two instances share clk, data_bus and cross-connected req/ack wires; sits between a local producer/consumer and the board-level link.

Parameters:
- DATA_W, 8, word width in bits.
- BUS_W, 1, bus width in bits; DATA_W must be a multiple of BUS_W (elaboration $error otherwise).
- ACK_TIMEOUT, 16, cycles spent in SEND_WAIT before giving up; must be ≥2.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  send request; accepted when start && tx_ready.
- tx_data  in  DATA_W  word to send; latched on acceptance.
- tx_ready  out  1  high only in IDLE with peer_req low.
- tx_done  out  1  one-cycle pulse: peer acknowledged.
- tx_err  out  1  one-cycle pulse: acknowledge timeout.
- peer_req  in  1  peer is driving the bus.
- peer_ack  in  1  peer acknowledge.
- own_req  out  1  this instance drives the bus.
- own_ack  out  1  acknowledge to peer.
- data_bus  inout  BUS_W  shared tri-state bus.
- rx_data  out  DATA_W  last received word; holds until the next good word.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- rx_err  out  1  one-cycle pulse: truncated (or, with the option, bad-parity) frame.

Behaviour:
- BEATS = DATA_W/BUS_W (+1 with the option). Beat k = word[k*BUS_W +: BUS_W].
- State enum: IDLE, SEND, SEND_WAIT, READ, ACK. A beat counter and a timeout counter are kept separately.
- Reset: state IDLE, counters 0, rx_data 0. All pulses and own_req/own_ack are 0. data_bus is Z.
- Reset mid-frame aborts at once; the peer sees a truncated frame.
- data_bus = beat[cnt] only while state==SEND, else Z. own_req = (state==SEND). own_ack = (state==ACK).
- IDLE transitions:
  - If peer_req=1: capture beat 0 from data_bus into the shift register, cnt=1, go to READ (or to ACK if BEATS==1).
  - Else if start: latch tx_data, cnt=0, go to SEND.
  - Receive has priority. start while peer_req=1 is ignored (tx_ready=0).
- SEND: cnt increments each cycle. After the beat with cnt==BEATS-1, go to SEND_WAIT with timer=0. Exactly BEATS cycles with own_req=1.
- SEND_WAIT:
  - peer_ack=1: go to IDLE, tx_done=1 in the next cycle.
  - Else timer++. When timer==ACK_TIMEOUT-1 with no ack: go to IDLE, tx_err=1 next cycle.
- READ:
  - peer_req=1: capture beat, cnt++. After the last beat go to ACK.
  - peer_req=0 before the last beat: go to IDLE, rx_err pulse, rx_data unchanged, no ack.
- ACK: one cycle. own_ack=1, rx_valid=1, rx_data = assembled word (registered on entry), then IDLE.
- Timing from start accepted at edge 0: bus beats in cycles 0..BEATS-1; the peer's rx_valid/ack in cycle BEATS; tx_done in cycle BEATS+1.
- After returning to IDLE, a new start is accepted at the next edge.
- peer_ack outside SEND_WAIT is ignored.

Optional Feature:
- Macro ASYNC_COM_PARITY_EN.
- Defined:
  - An extra final beat is sent: bit0 = even parity (XOR) of the word, other bits 0.
  - The receiver checks it. On mismatch: rx_err pulse, no ACK state, no rx_valid, rx_data unchanged; the sender then times out.
- Undefined: no parity beat; BEATS = DATA_W/BUS_W; the mismatch path does not exist.

Decomposition:
- Package async_com_pkg holds:
  - the state_t enum;
  - a function beats(DATA_W, BUS_W, parity);
  - a localparam for the counter width, $clog2(max(BEATS, ACK_TIMEOUT)+1).
- One sub-module, async_com_timer: load/clear, enable, expired output, parametrised by ACK_TIMEOUT; used in SEND_WAIT.

Test Plan:
- Two instances in loopback, DATA_W=8, BUS_W=2, A sends 0xB4 → bus beats 0,1,3,2 in cycles 0..3; B rx_valid with 0xB4 in cycle 4; A tx_done in cycle 5.
- A sends while B is held in reset (so no ack), ACK_TIMEOUT=16 → tx_err pulse exactly 16 cycles after entering SEND_WAIT; A returns to IDLE with bus Z.
- start and peer_req both high in IDLE → READ taken, start ignored, tx_ready=0; after the frame completes, start is accepted.
- Force peer_req low after 2 of 4 beats → rx_err pulse, rx_data keeps its previous value, own_ack never rises.
- Assert rst during beat 2 of a send → own_req=0, data_bus=Z, all pulses 0 immediately; the peer flags rx_err.
- With ASYNC_COM_PARITY_EN, corrupt the parity beat for word 0x01 → rx_err, no rx_valid; the sender reports tx_err after the timeout.
